ysyx_210544_trap_ctrl: RTL and testbench
========================================

Name: ysyx_210544_trap_ctrl

Overview:
Trap/return sequencer and CSR-port arbiter placed between the execute stage and the single-port CSR file. It owns the CSR file's read/write port. In idle it forwards CSR-instruction accesses. On an exception, a timer interrupt or an mret, it runs a fixed multi-cycle read-modify-write sequence on mstatus, mepc, mcause and mtvec, then issues one PC redirect to fetch.

Parameters:
VECTORED_EN, 1, honour mtvec.MODE=1 for interrupts: target = BASE + 4*cause[5:0]; when 0, target = BASE always.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_exc_req  in  1  exception request, held until o_req_ack
i_exc_cause  in  64  mcause value for the exception
i_exc_pc  in  64  faulting PC, written to mepc
i_mret_req  in  1  mret request, held until o_req_ack
i_irq_window  in  1  instruction boundary; interrupt may be taken
i_irq_pc  in  64  PC to resume after interrupt
i_clint_mtip  in  1  timer pending from CLINT
i_mstatus_mie  in  1  from CSR file (mstatus[3])
i_mie_mtie  in  1  from CSR file (mie[7])
i_inst_csr_ren  in  1  CSR-instruction read
i_inst_csr_wen  in  1  CSR-instruction write
i_inst_csr_addr  in  12  CSR-instruction address
i_inst_csr_wdata  in  64  CSR-instruction write data
o_inst_csr_rdata  out  64  read data to execute
o_inst_csr_ready  out  1  instruction access performed this cycle
o_csr_ren  out  1  to CSR file
o_csr_wen  out  1  to CSR file
o_csr_addr  out  12  to CSR file
o_csr_wdata  out  64  to CSR file
i_csr_rdata  in  64  from CSR file (combinational, same cycle)
o_req_ack  out  1  one-cycle pulse: request accepted
o_busy  out  1  state != IDLE
o_redirect_valid  out  1  one-cycle redirect pulse
o_redirect_pc  out  64  redirect target, valid with o_redirect_valid

Behaviour:
- Reset: state=IDLE. All outputs 0. Captured regs (cause, pc, mstatus copy, target) cleared. No CSR write is issued in the reset cycle. Reset mid-sequence aborts it; partial CSR writes already done are not undone.
- Accept in IDLE, priority: i_exc_req > i_mret_req > irq. irq = i_irq_window & i_clint_mtip & i_mstatus_mie & i_mie_mtie, with cause 64'h8000_0000_0000_0007 and pc = i_irq_pc.
- Accept cycle: o_req_ack=1 (exc/mret only). Capture cause/pc and the is_irq flag. Port stays idle and o_inst_csr_ready=0.
- IDLE with no accept: port = instruction passthrough (ren, wen, addr, wdata). o_inst_csr_rdata = i_csr_rdata. o_inst_csr_ready = ren|wen.
- Non-IDLE: o_inst_csr_ready=0 and o_inst_csr_rdata=0. Instruction inputs are ignored.
- Trap sequence, one state per cycle after accept T:
  - T+1 RD_MST: read 0x300, capture.
  - T+2 WR_MEPC: write 0x341 = pc with bits[1:0] cleared.
  - T+3 WR_MCAUSE: write 0x342 = cause.
  - T+4 WR_MST: write 0x300 = copy with MPIE[7]=MIE[3], MIE=0, MPP[12:11]=2'b11.
  - T+5 RD_MTVEC: read 0x305. target = {rdata[63:2],2'b00}, plus 4*cause[5:0] if VECTORED_EN & rdata[1:0]==1 & is_irq.
  - T+6 DONE: o_redirect_valid=1, then IDLE.
- Mret sequence:
  - T+1 RD_MST.
  - T+2 WR_MST: MIE=MPIE, MPIE=1, MPP=2'b11.
  - T+3 RD_MEPC: target = rdata.
  - T+4 DONE, then IDLE.
- A new request is only sampled in IDLE. DONE→IDLE takes one cycle, so back-to-back traps are spaced ≥1 idle cycle apart.
- SD bit recomputation is left to the CSR file; wdata passes other bits unchanged.
- Each sequence state drives exactly one of ren/wen; they are never both high.

Decomposition:
- CSR addresses (CSR_ADR_MSTATUS/MIE/MTVEC/MEPC/MCAUSE), mstatus bit positions (MIE=3, MPIE=7, MPP=12:11) and the timer-interrupt cause constant go in the shared defines.v.
- State encoding (3-bit localparams) stays local.
- Single module, no sub-module; the mstatus field update is a small local function.

Test Plan:
- Exception: mstatus=0x1808, mtvec=0x80000100. Pulse i_exc_req with cause=2, pc=0x80000044. Required: ack at T; mepc=0x80000044, mcause=2, mstatus=0x1880; redirect 0x80000100 at T+6.
- Timer irq: mtvec=0x80000101, MIE=1, MTIE=1, mtip=1, window=1, irq_pc=0x80000010. Required: mcause=0x8000000000000007, redirect 0x8000011C.
- Mret: mstatus=0x1880, mepc=0x80000048. Required: mstatus=0x1888, redirect 0x80000048 at T+4.
- Simultaneous exc+mret+irq: exception served first. mret remains held, is acked in the first IDLE after DONE, then completes.
- Instruction access during a trap: CSR read 0x341 issued at T+2. Required: ready=0 until the IDLE cycle after DONE, then rdata = new mepc.
- Reset asserted at T+3 of a trap. Required: next cycle IDLE, busy=0, no redirect, mstatus unchanged by the controller.

Source files
------------

// File: rtl/ysyx_210544_trap_ctrl_pkg.sv
// Shared CSR addresses, mstatus field positions and trap constants for the
// trap/return sequencer.
package ysyx_210544_trap_ctrl_pkg;

  localparam logic [11:0] CSR_ADR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ADR_MIE     = 12'h304;
  localparam logic [11:0] CSR_ADR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_ADR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ADR_MCAUSE  = 12'h342;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  localparam logic [63:0] CAUSE_MTIMER = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_210544_trap_ctrl.sv
// Trap/mret sequencer that owns the single CSR-file port: forwards instruction
// CSR accesses when idle and runs the fixed mstatus/mepc/mcause/mtvec sequence.
module ysyx_210544_trap_ctrl
  import ysyx_210544_trap_ctrl_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_exc_req,
  input  logic [63:0] i_exc_cause,
  input  logic [63:0] i_exc_pc,
  input  logic        i_mret_req,
  input  logic        i_irq_window,
  input  logic [63:0] i_irq_pc,
  input  logic        i_clint_mtip,
  input  logic        i_mstatus_mie,
  input  logic        i_mie_mtie,
  input  logic        i_inst_csr_ren,
  input  logic        i_inst_csr_wen,
  input  logic [11:0] i_inst_csr_addr,
  input  logic [63:0] i_inst_csr_wdata,
  output logic [63:0] o_inst_csr_rdata,
  output logic        o_inst_csr_ready,
  output logic        o_csr_ren,
  output logic        o_csr_wen,
  output logic [11:0] o_csr_addr,
  output logic [63:0] o_csr_wdata,
  input  logic [63:0] i_csr_rdata,
  output logic        o_req_ack,
  output logic        o_busy,
  output logic        o_redirect_valid,
  output logic [63:0] o_redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_MST    = 3'd1,
    S_WR_MEPC   = 3'd2,
    S_WR_MCAUSE = 3'd3,
    S_WR_MST    = 3'd4,
    S_RD_MTVEC  = 3'd5,
    S_RD_MEPC   = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t      r_state;
  logic [63:0] r_cause;
  logic [63:0] r_pc;
  logic [63:0] r_mst;
  logic [63:0] r_target;
  logic        r_is_irq;
  logic        r_is_mret;

  logic        w_irq;
  logic        w_accept;
  logic        w_vectored;
  logic [63:0] w_mtvec_target;

  // Trap entry stacks MIE into MPIE; mret pops it back. MPP is always M-mode.
  function automatic logic [63:0] mst_update(input logic [63:0] mst, input logic is_mret);
    logic [63:0] res;
    res = mst;
    if (is_mret) begin
      res[MST_MIE]  = mst[MST_MPIE];
      res[MST_MPIE] = 1'b1;
    end else begin
      res[MST_MPIE] = mst[MST_MIE];
      res[MST_MIE]  = 1'b0;
    end
    res[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    return res;
  endfunction

  assign w_irq    = i_irq_window & i_clint_mtip & i_mstatus_mie & i_mie_mtie;
  assign w_accept = (r_state == S_IDLE) & (i_exc_req | i_mret_req | w_irq);

  // Vectoring applies to interrupts only; exceptions always land on BASE.
  assign w_vectored     = VECTORED_EN & (i_csr_rdata[1:0] == 2'b01) & r_is_irq;
  assign w_mtvec_target = {i_csr_rdata[63:2], 2'b00}
                        + (w_vectored ? {56'd0, r_cause[5:0], 2'b00} : 64'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cause   <= '0;
      r_pc      <= '0;
      r_mst     <= '0;
      r_target  <= '0;
      r_is_irq  <= 1'b0;
      r_is_mret <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_exc_req) begin
            r_cause   <= i_exc_cause;
            r_pc      <= i_exc_pc;
            r_is_irq  <= 1'b0;
            r_is_mret <= 1'b0;
            r_state   <= S_RD_MST;
          end else if (i_mret_req) begin
            r_is_irq  <= 1'b0;
            r_is_mret <= 1'b1;
            r_state   <= S_RD_MST;
          end else if (w_irq) begin
            r_cause   <= CAUSE_MTIMER;
            r_pc      <= i_irq_pc;
            r_is_irq  <= 1'b1;
            r_is_mret <= 1'b0;
            r_state   <= S_RD_MST;
          end
        end
        S_RD_MST: begin
          r_mst   <= i_csr_rdata;
          r_state <= r_is_mret ? S_WR_MST : S_WR_MEPC;
        end
        S_WR_MEPC:   r_state <= S_WR_MCAUSE;
        S_WR_MCAUSE: r_state <= S_WR_MST;
        S_WR_MST:    r_state <= r_is_mret ? S_RD_MEPC : S_RD_MTVEC;
        S_RD_MTVEC: begin
          r_target <= w_mtvec_target;
          r_state  <= S_DONE;
        end
        S_RD_MEPC: begin
          r_target <= i_csr_rdata;
          r_state  <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves a latch behind. Reset forces all outputs low, including the port.
  always_comb begin
    o_inst_csr_rdata = '0;
    o_inst_csr_ready = 1'b0;
    o_csr_ren        = 1'b0;
    o_csr_wen        = 1'b0;
    o_csr_addr       = '0;
    o_csr_wdata      = '0;
    o_req_ack        = 1'b0;
    o_busy           = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    if (!rst) begin
      o_busy = (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          o_req_ack = i_exc_req | i_mret_req;
          if (!w_accept) begin
            o_csr_ren        = i_inst_csr_ren;
            o_csr_wen        = i_inst_csr_wen;
            o_csr_addr       = i_inst_csr_addr;
            o_csr_wdata      = i_inst_csr_wdata;
            o_inst_csr_rdata = i_csr_rdata;
            o_inst_csr_ready = i_inst_csr_ren | i_inst_csr_wen;
          end
        end
        S_RD_MST: begin
          o_csr_ren  = 1'b1;
          o_csr_addr = CSR_ADR_MSTATUS;
        end
        S_WR_MEPC: begin
          o_csr_wen   = 1'b1;
          o_csr_addr  = CSR_ADR_MEPC;
          o_csr_wdata = {r_pc[63:2], 2'b00};
        end
        S_WR_MCAUSE: begin
          o_csr_wen   = 1'b1;
          o_csr_addr  = CSR_ADR_MCAUSE;
          o_csr_wdata = r_cause;
        end
        S_WR_MST: begin
          o_csr_wen   = 1'b1;
          o_csr_addr  = CSR_ADR_MSTATUS;
          o_csr_wdata = mst_update(r_mst, r_is_mret);
        end
        S_RD_MTVEC: begin
          o_csr_ren  = 1'b1;
          o_csr_addr = CSR_ADR_MTVEC;
        end
        S_RD_MEPC: begin
          o_csr_ren  = 1'b1;
          o_csr_addr = CSR_ADR_MEPC;
        end
        S_DONE: begin
          o_redirect_valid = 1'b1;
          o_redirect_pc    = r_target;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_210544_trap_ctrl.sv
// Self-checking bench: a small CSR-file model answers the DUT port, a scoreboard
// holds the expected CSR writes and redirect targets in issue order.
module tb_ysyx_210544_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_exc_req = 1'b0;
  logic [63:0] i_exc_cause = '0;
  logic [63:0] i_exc_pc = '0;
  logic        i_mret_req = 1'b0;
  logic        i_irq_window = 1'b0;
  logic [63:0] i_irq_pc = '0;
  logic        i_clint_mtip = 1'b0;
  logic        i_inst_csr_ren = 1'b0;
  logic        i_inst_csr_wen = 1'b0;
  logic [11:0] i_inst_csr_addr = '0;
  logic [63:0] i_inst_csr_wdata = '0;
  logic [63:0] o_inst_csr_rdata;
  logic        o_inst_csr_ready;
  logic        o_csr_ren, o_csr_wen;
  logic [11:0] o_csr_addr;
  logic [63:0] o_csr_wdata;
  logic [63:0] i_csr_rdata;
  logic        o_req_ack, o_busy, o_redirect_valid;
  logic [63:0] o_redirect_pc;

  logic [63:0] m_mstatus = '0, m_mie = '0, m_mtvec = '0, m_mepc = '0, m_mcause = '0;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
  } wr_t;
  wr_t         exp_wr[$];
  logic [63:0] exp_rd[$];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] CAUSE_TMR = 64'h8000_0000_0000_0007;

  always #5 clk = ~clk;

  ysyx_210544_trap_ctrl #(.VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_exc_req(i_exc_req), .i_exc_cause(i_exc_cause), .i_exc_pc(i_exc_pc),
    .i_mret_req(i_mret_req), .i_irq_window(i_irq_window), .i_irq_pc(i_irq_pc),
    .i_clint_mtip(i_clint_mtip), .i_mstatus_mie(m_mstatus[3]), .i_mie_mtie(m_mie[7]),
    .i_inst_csr_ren(i_inst_csr_ren), .i_inst_csr_wen(i_inst_csr_wen),
    .i_inst_csr_addr(i_inst_csr_addr), .i_inst_csr_wdata(i_inst_csr_wdata),
    .o_inst_csr_rdata(o_inst_csr_rdata), .o_inst_csr_ready(o_inst_csr_ready),
    .o_csr_ren(o_csr_ren), .o_csr_wen(o_csr_wen), .o_csr_addr(o_csr_addr),
    .o_csr_wdata(o_csr_wdata), .i_csr_rdata(i_csr_rdata),
    .o_req_ack(o_req_ack), .o_busy(o_busy),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc)
  );

  // CSR file model: combinational read, write on the clock edge.
  always_comb begin
    i_csr_rdata = '0;
    case (o_csr_addr)
      12'h300: i_csr_rdata = m_mstatus;
      12'h304: i_csr_rdata = m_mie;
      12'h305: i_csr_rdata = m_mtvec;
      12'h341: i_csr_rdata = m_mepc;
      12'h342: i_csr_rdata = m_mcause;
      default: i_csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (o_csr_wen) begin
      case (o_csr_addr)
        12'h300: m_mstatus <= o_csr_wdata;
        12'h304: m_mie     <= o_csr_wdata;
        12'h305: m_mtvec   <= o_csr_wdata;
        12'h341: m_mepc    <= o_csr_wdata;
        12'h342: m_mcause  <= o_csr_wdata;
        default: ;
      endcase
    end
  end

  // Scoreboard monitor: every issued write and redirect is popped and compared.
  always @(negedge clk) begin
    if (o_csr_ren | o_csr_wen) begin
      n_checks++;
      if (o_csr_ren & o_csr_wen) begin
        n_fail++;
        $display("FAIL port_exclusive: ren=%b wen=%b required not both high", o_csr_ren, o_csr_wen);
      end
    end
    if (o_csr_wen) begin
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL csr_write: unexpected write addr=%h data=%h", o_csr_addr, o_csr_wdata);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        if (o_csr_addr !== e.addr || o_csr_wdata !== e.data) begin
          n_fail++;
          $display("FAIL csr_write: got addr=%h data=%h required addr=%h data=%h",
                   o_csr_addr, o_csr_wdata, e.addr, e.data);
        end
      end
    end
    if (o_redirect_valid) begin
      n_checks++;
      if (exp_rd.size() == 0) begin
        n_fail++;
        $display("FAIL redirect: unexpected redirect pc=%h", o_redirect_pc);
      end else begin
        logic [63:0] t;
        t = exp_rd.pop_front();
        if (o_redirect_pc !== t) begin
          n_fail++;
          $display("FAIL redirect: got pc=%h required %h", o_redirect_pc, t);
        end
      end
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [63:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i_exc_req = 1'b1;
    i_inst_csr_ren = 1'b1;
    i_inst_csr_wen = 1'b1;
    i_inst_csr_addr = 12'h300;
    i_inst_csr_wdata = 64'hdead;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_req_ack, o_busy, o_redirect_valid, o_csr_ren, o_csr_wen, o_inst_csr_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ack/busy/redir/ren/wen/ready=%b required 000000",
               {o_req_ack, o_busy, o_redirect_valid, o_csr_ren, o_csr_wen, o_inst_csr_ready});
    end
    n_checks++;
    if (o_csr_addr !== 12'h0 || o_csr_wdata !== 64'h0 || o_inst_csr_rdata !== 64'h0 || o_redirect_pc !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h rpc=%h required all 0",
               o_csr_addr, o_csr_wdata, o_inst_csr_rdata, o_redirect_pc);
    end
    i_exc_req = 1'b0;
    i_inst_csr_ren = 1'b0;
    i_inst_csr_wen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_passthrough;
    @(posedge clk); #1;
    m_mstatus = 64'h1234_0008;
    m_mie = 64'h0;
    push_wr(12'h304, 64'h80);
    i_inst_csr_wen = 1'b1;
    i_inst_csr_addr = 12'h304;
    i_inst_csr_wdata = 64'h80;
    @(negedge clk);
    n_checks++;
    if (o_inst_csr_ready !== 1'b1 || o_csr_addr !== 12'h304 || o_csr_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_write: ready=%b addr=%h ren=%b required 1 304 0",
               o_inst_csr_ready, o_csr_addr, o_csr_ren);
    end
    @(posedge clk); #1;
    i_inst_csr_wen = 1'b0;
    i_inst_csr_ren = 1'b1;
    i_inst_csr_addr = 12'h300;
    @(negedge clk);
    n_checks++;
    if (o_inst_csr_ready !== 1'b1 || o_inst_csr_rdata !== 64'h1234_0008 || o_csr_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_read: ready=%b rdata=%h wen=%b required 1 0000000012340008 0",
               o_inst_csr_ready, o_inst_csr_rdata, o_csr_wen);
    end
    @(posedge clk); #1;
    i_inst_csr_ren = 1'b0;
    n_checks++;
    if (m_mie !== 64'h80) begin
      n_fail++;
      $display("FAIL pass_mie: mie=%h required 80", m_mie);
    end
  endtask

  task automatic test_exception;
    m_mstatus = 64'h1808;
    m_mie = 64'h0;
    m_mtvec = 64'h8000_0100;
    push_wr(12'h341, 64'h8000_0044);
    push_wr(12'h342, 64'h2);
    push_wr(12'h300, 64'h1880);
    exp_rd.push_back(64'h8000_0100);
    i_exc_req = 1'b1;
    i_exc_cause = 64'h2;
    i_exc_pc = 64'h8000_0044;
    @(negedge clk);
    n_checks++;
    if (o_req_ack !== 1'b1 || o_inst_csr_ready !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_accept: ack=%b ready=%b busy=%b required 1 0 0", o_req_ack, o_inst_csr_ready, o_busy);
    end
    @(posedge clk); #1;
    i_exc_req = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_redirect_valid !== (k == 6) || o_busy !== (k <= 6)) begin
        n_fail++;
        $display("FAIL exc_timing T+%0d: redirect=%b busy=%b required %b %b",
                 k, o_redirect_valid, o_busy, (k == 6), (k <= 6));
      end
    end
    n_checks++;
    if (m_mepc !== 64'h8000_0044 || m_mcause !== 64'h2 || m_mstatus !== 64'h1880) begin
      n_fail++;
      $display("FAIL exc_csrs: mepc=%h mcause=%h mstatus=%h required 80000044 2 1880",
               m_mepc, m_mcause, m_mstatus);
    end
  endtask

  task automatic test_irq;
    @(posedge clk); #1;
    m_mstatus = 64'h1808;
    m_mie = 64'h0;
    m_mtvec = 64'h8000_0101;
    i_clint_mtip = 1'b1;
    i_irq_window = 1'b1;
    i_irq_pc = 64'h8000_0010;
    @(posedge clk); #1;
    i_irq_window = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked: busy=%b required 0 with MTIE=0", o_busy);
    end
    @(posedge clk); #1;
    m_mie = 64'h80;
    push_wr(12'h341, 64'h8000_0010);
    push_wr(12'h342, CAUSE_TMR);
    push_wr(12'h300, 64'h1880);
    exp_rd.push_back(64'h8000_011C);
    i_irq_window = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_req_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_noack: ack=%b required 0", o_req_ack);
    end
    @(posedge clk); #1;
    i_irq_window = 1'b0;
    i_clint_mtip = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_redirect_valid !== (k == 6) || o_busy !== (k <= 6)) begin
        n_fail++;
        $display("FAIL irq_timing T+%0d: redirect=%b busy=%b required %b %b",
                 k, o_redirect_valid, o_busy, (k == 6), (k <= 6));
      end
    end
    n_checks++;
    if (m_mcause !== CAUSE_TMR || m_mepc !== 64'h8000_0010) begin
      n_fail++;
      $display("FAIL irq_csrs: mcause=%h mepc=%h required 8000000000000007 80000010", m_mcause, m_mepc);
    end
  endtask

  task automatic test_mret;
    @(posedge clk); #1;
    m_mstatus = 64'h1880;
    m_mepc = 64'h8000_0048;
    push_wr(12'h300, 64'h1888);
    exp_rd.push_back(64'h8000_0048);
    i_mret_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_req_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL mret_accept: ack=%b required 1", o_req_ack);
    end
    @(posedge clk); #1;
    i_mret_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_redirect_valid !== (k == 4) || o_busy !== (k <= 4)) begin
        n_fail++;
        $display("FAIL mret_timing T+%0d: redirect=%b busy=%b required %b %b",
                 k, o_redirect_valid, o_busy, (k == 4), (k <= 4));
      end
    end
    n_checks++;
    if (m_mstatus !== 64'h1888) begin
      n_fail++;
      $display("FAIL mret_mstatus: mstatus=%h required 1888", m_mstatus);
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    m_mstatus = 64'h1808;
    m_mie = 64'h80;
    m_mtvec = 64'h8000_0101;
    m_mepc = 64'h0;
    push_wr(12'h341, 64'h8000_0080);
    push_wr(12'h342, 64'h4);
    push_wr(12'h300, 64'h1880);
    exp_rd.push_back(64'h8000_0100);
    push_wr(12'h300, 64'h1888);
    exp_rd.push_back(64'h8000_0080);
    i_exc_req = 1'b1;
    i_exc_cause = 64'h4;
    i_exc_pc = 64'h8000_0080;
    i_mret_req = 1'b1;
    i_clint_mtip = 1'b1;
    i_irq_window = 1'b1;
    i_irq_pc = 64'h8000_0bb0;
    @(negedge clk);
    n_checks++;
    if (o_req_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: ack=%b required 1", o_req_ack);
    end
    @(posedge clk); #1;
    i_exc_req = 1'b0;
    i_irq_window = 1'b0;
    i_clint_mtip = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_redirect_valid !== (k == 6) || o_req_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_exc T+%0d: redirect=%b ack=%b required %b 0", k, o_redirect_valid, o_req_ack, (k == 6));
      end
    end
    @(negedge clk);
    n_checks++;
    if (o_req_ack !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_mret_ack: ack=%b busy=%b required 1 0", o_req_ack, o_busy);
    end
    @(posedge clk); #1;
    i_mret_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_redirect_valid !== (k == 4)) begin
        n_fail++;
        $display("FAIL b2b_mret T+%0d: redirect=%b required %b", k, o_redirect_valid, (k == 4));
      end
    end
    n_checks++;
    if (m_mstatus !== 64'h1888 || m_mcause !== 64'h4) begin
      n_fail++;
      $display("FAIL b2b_csrs: mstatus=%h mcause=%h required 1888 4", m_mstatus, m_mcause);
    end
  endtask

  task automatic test_inst_during_trap;
    @(posedge clk); #1;
    m_mstatus = 64'h1808;
    m_mie = 64'h0;
    m_mtvec = 64'h8000_0100;
    push_wr(12'h341, 64'h8000_00A0);
    push_wr(12'h342, 64'h5);
    push_wr(12'h300, 64'h1880);
    exp_rd.push_back(64'h8000_0100);
    i_exc_req = 1'b1;
    i_exc_cause = 64'h5;
    i_exc_pc = 64'h8000_00A0;
    @(negedge clk);
    @(posedge clk); #1;
    i_exc_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    i_inst_csr_ren = 1'b1;
    i_inst_csr_addr = 12'h341;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_inst_csr_ready !== 1'b0 || o_inst_csr_rdata !== 64'h0) begin
        n_fail++;
        $display("FAIL inst_blocked T+%0d: ready=%b rdata=%h required 0 0", k, o_inst_csr_ready, o_inst_csr_rdata);
      end
    end
    @(negedge clk);
    n_checks++;
    if (o_inst_csr_ready !== 1'b1 || o_inst_csr_rdata !== 64'h8000_00A0) begin
      n_fail++;
      $display("FAIL inst_after: ready=%b rdata=%h required 1 800000a0", o_inst_csr_ready, o_inst_csr_rdata);
    end
    @(posedge clk); #1;
    i_inst_csr_ren = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    m_mstatus = 64'h1808;
    m_mcause = 64'h55;
    m_mepc = 64'h0;
    m_mtvec = 64'h8000_0100;
    push_wr(12'h341, 64'h8000_0200);
    i_exc_req = 1'b1;
    i_exc_cause = 64'h3;
    i_exc_pc = 64'h8000_0202;
    @(negedge clk);
    @(posedge clk); #1;
    i_exc_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_csr_wen !== 1'b0 || o_busy !== 1'b0 || o_redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_cycle: wen=%b busy=%b redirect=%b required 0 0 0", o_csr_wen, o_busy, o_redirect_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b0 || o_redirect_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_idle +%0d: busy=%b redirect=%b required 0 0", k, o_busy, o_redirect_valid);
      end
    end
    n_checks++;
    if (m_mstatus !== 64'h1808 || m_mcause !== 64'h55 || m_mepc !== 64'h8000_0200) begin
      n_fail++;
      $display("FAIL rst_mid_csrs: mstatus=%h mcause=%h mepc=%h required 1808 55 80000200",
               m_mstatus, m_mcause, m_mepc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_exception();
    test_irq();
    test_mret();
    test_back_to_back();
    test_inst_during_trap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d writes and %0d redirects never seen", exp_wr.size(), exp_rd.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
